// File: rtl/pipe_stall_ctrl_pkg.sv
// Purpose: shared state encodings and sizing constants for the pipeline stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BUBBLE  = 2'd1,
    ST_MWAIT   = 2'd2,
    ST_TIMEOUT = 2'd3
  } stall_state_e;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int PERF_CNT_W      = 32;

endpackage

// File: rtl/pipe_stall_ctrl_perf.sv
// Purpose: 32-bit saturating event counter with synchronous clear.
// Latency: count visible one cycle after i_inc.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, i_clr (sync clear, wins over inc), i_inc (count enable), o_cnt (current count).
module stall_perf_cnt
  import pipe_stall_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [PERF_CNT_W-1:0] o_cnt
);

  logic [PERF_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + PERF_CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Purpose: pipeline stall/flush controller (load-use bubble, branch flush, memory wait, timeout).
// Latency: enables/flushes are combinational from state and inputs (same cycle).
// Backpressure: freezes PC..EXMEM while data memory is not ready; stuck in TIMEOUT until rst.
// Ports: clk, rst (sync, active-high); load_use, M_BranchTaken, M_MemReq, mem_ready in;
//        PC_en/IFID_en/IDEX_en/EXMEM_en, IFID/IDEX/EXMEM/MEMWB_flush, mem_err, stall_state out.
// Optional: STALL_PERF_CNT_EN adds lu_stall_cnt, mem_stall_cnt, flush_cnt (32-bit, saturating).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_use,
  input  logic       M_BranchTaken,
  input  logic       M_MemReq,
  input  logic       mem_ready,
  output logic       PC_en,
  output logic       IFID_en,
  output logic       IDEX_en,
  output logic       EXMEM_en,
  output logic       IFID_flush,
  output logic       IDEX_flush,
  output logic       EXMEM_flush,
  output logic       MEMWB_flush,
  output logic       mem_err,
  output logic [1:0] stall_state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] lu_stall_cnt,
  output logic [PERF_CNT_W-1:0] mem_stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  localparam int             CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  stall_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic w_mem_wait;
  logic w_use_run;     // evaluate the RUN priority chain this cycle
  logic w_chk_mwait;   // mem wait participates (false once MWAIT sees ready)
  logic w_lu_ok;       // load_use honoured (ignored in BUBBLE)
  logic w_lu_fire, w_mem_fire, w_br_fire;

  assign w_mem_wait = M_MemReq & ~mem_ready;

  always_comb begin
    PC_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    MEMWB_flush = 1'b0;
    mem_err     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_use_run   = 1'b0;
    w_chk_mwait = 1'b0;
    w_lu_ok     = 1'b0;
    w_lu_fire   = 1'b0;
    w_mem_fire  = 1'b0;
    w_br_fire   = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_use_run   = 1'b1;
        w_chk_mwait = 1'b1;
        w_lu_ok     = 1'b1;
      end
      ST_BUBBLE: begin
        w_use_run   = 1'b1;
        w_chk_mwait = 1'b1;
      end
      ST_MWAIT: begin
        if (!mem_ready) begin
          w_mem_fire = 1'b1;
          // Counter saturates at the limit; that cycle escalates instead of counting on.
          if (r_cnt == TMO) begin
            w_state_nxt = ST_TIMEOUT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_use_run = 1'b1;
          w_lu_ok   = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      ST_TIMEOUT: begin
        PC_en       = 1'b0;
        IFID_en     = 1'b0;
        IDEX_en     = 1'b0;
        EXMEM_en    = 1'b0;
        MEMWB_flush = 1'b1;
        mem_err     = 1'b1;
      end
    endcase

    if (w_use_run) begin
      if (w_chk_mwait && w_mem_wait) begin
        w_mem_fire  = 1'b1;
        w_state_nxt = ST_MWAIT;
        w_cnt_nxt   = CNT_W'(1);
      end else if (M_BranchTaken) begin
        w_br_fire   = 1'b1;
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end else if (w_lu_ok && load_use) begin
        w_lu_fire   = 1'b1;
        w_state_nxt = ST_BUBBLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    end

    if (w_mem_fire) begin
      PC_en       = 1'b0;
      IFID_en     = 1'b0;
      IDEX_en     = 1'b0;
      EXMEM_en    = 1'b0;
      MEMWB_flush = 1'b1;
    end
    if (w_br_fire) begin
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
    end
    if (w_lu_fire) begin
      PC_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_flush = 1'b1;
    end

    // Reset holds the whole pipe frozen with bubbles in every stage.
    if (rst) begin
      PC_en       = 1'b0;
      IFID_en     = 1'b0;
      IDEX_en     = 1'b0;
      EXMEM_en    = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
      MEMWB_flush = 1'b1;
      mem_err     = 1'b0;
      w_lu_fire   = 1'b0;
      w_mem_fire  = 1'b0;
      w_br_fire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign stall_state = rst ? 2'(ST_RUN) : r_state;

`ifdef STALL_PERF_CNT_EN
  stall_perf_cnt u_lu_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_lu_fire),
    .o_cnt (lu_stall_cnt)
  );

  stall_perf_cnt u_mem_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_mem_fire),
    .o_cnt (mem_stall_cnt)
  );

  stall_perf_cnt u_flush_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_br_fire),
    .o_cnt (flush_cnt)
  );
`else
  logic w_unused_fires;
  assign w_unused_fires = ^{w_lu_fire, w_mem_fire, w_br_fire};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Purpose: self-checking bench for pipe_stall_ctrl against a rule-level reference model.
// Latency: outputs checked mid-cycle against expectations for the current inputs.
// Backpressure: n/a.
module tb_pipe_stall_ctrl;

  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load_use, M_BranchTaken, M_MemReq, mem_ready;
  logic PC_en, IFID_en, IDEX_en, EXMEM_en;
  logic IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush;
  logic mem_err;
  logic [1:0] stall_state;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

  pipe_stall_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_use      (load_use),
    .M_BranchTaken (M_BranchTaken),
    .M_MemReq      (M_MemReq),
    .mem_ready     (mem_ready),
    .PC_en         (PC_en),
    .IFID_en       (IFID_en),
    .IDEX_en       (IDEX_en),
    .EXMEM_en      (EXMEM_en),
    .IFID_flush    (IFID_flush),
    .IDEX_flush    (IDEX_flush),
    .EXMEM_flush   (EXMEM_flush),
    .MEMWB_flush   (MEMWB_flush),
    .mem_err       (mem_err),
    .stall_state   (stall_state)
`ifdef STALL_PERF_CNT_EN
    ,
    .lu_stall_cnt  (lu_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  string scn = "init";

  // Reference model: how many consecutive wait cycles have elapsed, whether the
  // previous cycle inserted a load-use bubble, and whether the timeout latched.
  int          m_waits  = 0;
  bit          m_bubble = 1'b0;
  bit          m_err    = 1'b0;
  int unsigned m_lu = 0, m_mem = 0, m_fl = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", scn, tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit lu, input bit br, input bit mq, input bit rdy);
    logic [3:0] e_en, e_fl;
    logic       e_err;
    logic [1:0] e_st;
    bit         in_wait, stall;
    in_wait = 1'b0;
    stall   = 1'b0;
    @(negedge clk);
    rst = r; load_use = lu; M_BranchTaken = br; M_MemReq = mq; mem_ready = rdy;
    #1;
    e_en = 4'hF; e_fl = 4'h0; e_err = 1'b0; e_st = 2'd0;
    if (r) begin
      e_en = 4'h0; e_fl = 4'hF;
    end else if (m_err) begin
      e_en = 4'h0; e_fl = 4'b0001; e_err = 1'b1; e_st = 2'd3;
    end else begin
      in_wait = (m_waits > 0);
      e_st    = in_wait ? 2'd2 : (m_bubble ? 2'd1 : 2'd0);
      stall   = in_wait ? !rdy : (mq && !rdy);
      if (stall) begin
        e_en = 4'h0; e_fl = 4'b0001;
      end else if (br) begin
        e_fl = 4'b1110;
      end else if (lu && !m_bubble) begin
        e_en = 4'b0011; e_fl = 4'b0100;
      end
    end
    check("enables", {28'd0, PC_en, IFID_en, IDEX_en, EXMEM_en}, {28'd0, e_en});
    check("flushes", {28'd0, IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush}, {28'd0, e_fl});
    check("mem_err", {31'd0, mem_err}, {31'd0, e_err});
    check("state", {30'd0, stall_state}, {30'd0, e_st});
`ifdef STALL_PERF_CNT_EN
    if (!r) begin
      check("lu_cnt", lu_stall_cnt, m_lu);
      check("mem_cnt", mem_stall_cnt, m_mem);
      check("flush_cnt", flush_cnt, m_fl);
    end
`endif
    // Advance the model to what should hold after this clock edge.
    if (r) begin
      m_waits = 0; m_bubble = 1'b0; m_err = 1'b0; m_lu = 0; m_mem = 0; m_fl = 0;
    end else if (!m_err) begin
      if (stall) begin
        m_mem++;
        m_bubble = 1'b0;
        if (in_wait && m_waits == T) begin
          m_err = 1'b1; m_waits = 0;
        end else begin
          m_waits++;
        end
      end else if (br) begin
        m_fl++; m_waits = 0; m_bubble = 1'b0;
      end else if (lu && !m_bubble) begin
        m_lu++; m_waits = 0; m_bubble = 1'b1;
      end else begin
        m_waits = 0; m_bubble = 1'b0;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; load_use = 1'b0; M_BranchTaken = 1'b0; M_MemReq = 1'b0; mem_ready = 1'b0;

    scn = "reset";
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    idle();

    scn = "load_use";
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);   // bubble: load_use ignored
    idle();

    scn = "lu_and_branch";
    step(0, 1, 1, 0, 0);
    idle();

    scn = "mem_wait3";
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    idle();

    scn = "timeout";
    for (int i = 0; i < T + 3; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1);   // still stuck
    step(1, 0, 0, 1, 0);
    idle();

    scn = "bubble_to_mwait";
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 1);   // ready cycle honours load_use
    idle();
    idle();

    scn = "reset_mid_wait";
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    idle();

    scn = "perf";
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle();
    step(0, 1, 0, 0, 0);
    idle();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    @(negedge clk);
    rst = 1'b0; load_use = 1'b0; M_BranchTaken = 1'b0; M_MemReq = 1'b0; mem_ready = 1'b0;
    #1;
`ifdef STALL_PERF_CNT_EN
    check("lu_total", lu_stall_cnt, 32'd2);
    check("mem_total", mem_stall_cnt, 32'd5);
    check("flush_total", flush_cnt, 32'd0);
`endif
    check("state_after", {30'd0, stall_state}, 32'd0);

    scn = "random";
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) < 3),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum consecutive cycles a MEM-stage access SHALL wait for mem_ready before the error state is entered.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: load_use  input  1  load-use hazard flag from the hazard detector.
REQ-005 Port: M_BranchTaken  input  1  branch resolved taken in MEM.
REQ-006 Port: M_MemReq  input  1  MEM-stage instruction accesses data memory this cycle.
REQ-007 Port: mem_ready  input  1  data memory completes the access this cycle.
REQ-008 Ports: PC_en, IFID_en, IDEX_en, EXMEM_en  output  1 each  pipeline register write enables.
REQ-009 Ports: IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush  output  1 each  bubble-insert controls.
REQ-010 Port: mem_err  output  1  sticky memory-timeout flag.
REQ-011 Port: stall_state  output  2  current FSM state encoding.

Function
REQ-012 FSM states SHALL be RUN=0, BUBBLE=1, MWAIT=2, TIMEOUT=3.
REQ-013 Outputs SHALL be combinational from state and inputs (zero-cycle latency); the hazard SHALL be acted on in the cycle it is flagged.
REQ-014 Default outputs SHALL be all enables 1 and all flushes 0.
REQ-015 In RUN, condition priority SHALL be: mem wait > branch > load-use.
REQ-016 Mem wait (M_MemReq=1, mem_ready=0): PC_en, IFID_en, IDEX_en, EXMEM_en=0; MEMWB_flush=1; next state MWAIT; timeout counter loads 1.
REQ-017 Branch (M_BranchTaken=1, no mem wait): IFID_flush, IDEX_flush, EXMEM_flush=1; PC_en=1; load_use ignored; next state RUN.
REQ-018 Load-use (load_use=1, no mem wait, no branch): PC_en=0, IFID_en=0, IDEX_flush=1; next state BUBBLE.
REQ-019 BUBBLE SHALL last one cycle and SHALL apply the RUN rules except that load_use is ignored; next state RUN, or MWAIT on mem wait.
REQ-020 In MWAIT with mem_ready=0, outputs SHALL be as in REQ-016 and the counter SHALL increment.
REQ-021 In MWAIT with mem_ready=0 and counter == MEM_TIMEOUT, next state SHALL be TIMEOUT.
REQ-022 In MWAIT with mem_ready=1, the RUN rules with mem wait false SHALL apply in the same cycle, and the counter SHALL clear.
REQ-023 TIMEOUT SHALL assert mem_err=1, deassert all enables, assert MEMWB_flush, and persist until rst.
REQ-024 Counter width SHALL be clog2(MEM_TIMEOUT+1) and the counter SHALL never wrap.

Reset
REQ-025 While rst=1: state RUN, counter 0, mem_err 0, all enables 0, all flushes 1, stall_state 0.
REQ-026 rst asserted mid-MWAIT or mid-TIMEOUT SHALL return the block to RUN on the next edge.

Configuration
REQ-027 Macro STALL_PERF_CNT_EN defined: add 32-bit outputs lu_stall_cnt, mem_stall_cnt, flush_cnt, which saturate at 0xFFFFFFFF and clear on rst.
REQ-028 lu_stall_cnt SHALL count cycles in which REQ-018 fires, mem_stall_cnt SHALL count cycles in which REQ-016 or REQ-020 fires, and flush_cnt SHALL count cycles in which REQ-017 fires.
REQ-029 Macro STALL_PERF_CNT_EN undefined: the counter ports and logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-030 A shared package SHALL hold the state encodings, the MEM_TIMEOUT default and the 32-bit counter width constant.
REQ-031 One sub-module, stall_perf_cnt (32-bit saturating counter with inc/clr), SHALL be instantiated three times, only under STALL_PERF_CNT_EN.

Verification
REQ-032 Scenario: load_use=1 for 1 cycle in RUN -> PC_en=0, IFID_en=0, IDEX_flush=1 that cycle; stall_state=1 next; RUN after.
REQ-033 Scenario: load_use=1 and M_BranchTaken=1 together -> flushes IFID, IDEX and EXMEM, PC_en=1, state stays RUN.
REQ-034 Scenario: M_MemReq=1, mem_ready low 3 cycles then high -> 3 frozen cycles with MEMWB_flush=1; all enables 1 on the ready cycle; RUN.
REQ-035 Scenario: MEM_TIMEOUT=4, mem_ready held 0 -> TIMEOUT after 4 wait cycles; mem_err=1 sticky; rst clears to RUN.
REQ-036 Scenario: load_use then mem wait in BUBBLE -> MWAIT entered from BUBBLE; load_use during BUBBLE ignored.
REQ-037 Scenario: with STALL_PERF_CNT_EN, 2 load-use stalls and 5 mem-wait cycles -> lu_stall_cnt=2, mem_stall_cnt=5, flush_cnt=0.
